// File: rtl/mips20_pkg.sv
// Shared MIPS-20 definitions: opcode map, instruction field positions,
// the NOP word and the fetch FSM state encoding.
package mips20_pkg;

   localparam int OPC_HI = 19;
   localparam int OPC_LO = 16;
   localparam int TGT_HI = 15;
   localparam int TGT_LO = 0;

   typedef enum logic [3:0] {
      OP_RTYPE = 4'd0,
      OP_ADDI  = 4'd1,
      OP_ANDI  = 4'd2,
      OP_STW   = 4'd3,
      OP_LW    = 4'd4,
      OP_SW    = 4'd5,
      OP_BEQ   = 4'd6,
      OP_JUMP  = 4'd7,
      OP_JMEM  = 4'd8
   } opcode_t;

   localparam logic [19:0] NOP_WORD = 20'h00000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [19:0] word);
      return word[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [15:0] jump_target_of(input logic [19:0] word);
      return word[TGT_HI:TGT_LO];
   endfunction

endpackage

// File: rtl/instruction_fetch_pipeline_if.sv
// Fetch-stage bus: control from ID/EX, the instruction memory port and the IF/ID register view.
interface instruction_fetch_pipeline_if #(
   parameter int ADDR_W  = 20,
   parameter int INSTR_W = 20
);
   logic               stall_i;
   logic               redirect_i;
   logic [ADDR_W-1:0]  redirect_pc_i;
   logic [ADDR_W-1:0]  imem_addr_o;
   logic [INSTR_W-1:0] imem_instr_i;
   logic [INSTR_W-1:0] if_id_instr_o;
   logic [ADDR_W-1:0]  if_id_pc_o;
   logic [ADDR_W-1:0]  if_id_pc1_o;
   logic               if_id_valid_o;
   logic               halted_o;
   logic [15:0]        fetch_count_o;

   modport master (
      input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      output imem_addr_o, if_id_instr_o, if_id_pc_o, if_id_pc1_o,
             if_id_valid_o, halted_o, fetch_count_o
   );

   modport slave (
      output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
      input  imem_addr_o, if_id_instr_o, if_id_pc_o, if_id_pc1_o,
             if_id_valid_o, halted_o, fetch_count_o
   );
endinterface

// File: rtl/instruction_fetch_pipeline_fetch_next_pc.sv
// Next-PC priority mux: redirect > halt/out-of-range hold > stall hold > early jump > PC+1.
module fetch_next_pc
   import mips20_pkg::*;
#(
   parameter int ADDR_W     = 20,
   parameter int INSTR_W    = 20,
   parameter int IMEM_DEPTH = 13
) (
   input  logic               halted,
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  next_pc,
   output logic [ADDR_W-1:0]  pc_plus1,
   output logic               in_range,
   output logic               is_jump
);

   always_comb begin
      pc_plus1 = pc + ADDR_W'(1);
      in_range = (pc < ADDR_W'(IMEM_DEPTH));
      is_jump  = (instr[OPC_HI:OPC_LO] == OP_JUMP);
      next_pc  = pc_plus1;
      if (redirect)
         next_pc = redirect_pc;
      else if (halted || !in_range || stall)
         next_pc = pc;
      else if (is_jump)
         next_pc = ADDR_W'(instr[TGT_HI:TGT_LO]);
   end

endmodule

// File: rtl/instruction_fetch_pipeline.sv
// Fetch stage: owns the PC, drives the combinational imem address and loads the IF/ID register.
//  state   | meaning
//  ST_RUN  | fetching; PC advances, jumps or holds on stall
//  ST_HALT | PC ran past populated memory; wait for redirect
module instruction_fetch_pipeline
   import mips20_pkg::*;
#(
   parameter int                 ADDR_W      = 20,
   parameter int                 INSTR_W     = 20,
   parameter logic [ADDR_W-1:0]  RESET_PC    = 20'd0,
   parameter int                 IMEM_DEPTH  = 13,
   parameter logic [INSTR_W-1:0] NOP_INSTR   = NOP_WORD,
   parameter logic [15:0]        COUNT_RESET = 16'h0000
) (
   input  logic                        clk,
   input  logic                        rst,
   instruction_fetch_pipeline_if.master bus
);

   fetch_state_t       state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  next_pc;
   logic [ADDR_W-1:0]  pc_plus1;
   logic               in_range;
   logic               is_jump;
   logic [INSTR_W-1:0] if_id_instr;
   logic [ADDR_W-1:0]  if_id_pc;
   logic [ADDR_W-1:0]  if_id_pc1;
   logic               if_id_valid;
   logic [15:0]        fetch_count;

   fetch_next_pc #(
      .ADDR_W     (ADDR_W),
      .INSTR_W    (INSTR_W),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_next_pc (
      .halted      (state == ST_HALT),
      .pc          (pc),
      .instr       (bus.imem_instr_i),
      .stall       (bus.stall_i),
      .redirect    (bus.redirect_i),
      .redirect_pc (bus.redirect_pc_i),
      .next_pc     (next_pc),
      .pc_plus1    (pc_plus1),
      .in_range    (in_range),
      .is_jump     (is_jump)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         pc          <= RESET_PC;
         if_id_instr <= NOP_INSTR;
         if_id_pc    <= '0;
         if_id_pc1   <= '0;
         if_id_valid <= 1'b0;
         fetch_count <= COUNT_RESET;
      end else begin
         pc <= next_pc;
         if (bus.redirect_i) begin
            state       <= ST_RUN;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (state == ST_HALT) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (!in_range) begin
            // memory word past the populated range is garbage; never let it reach decode
            state       <= ST_HALT;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end else if (!bus.stall_i) begin
            // a jump word still goes to decode, which treats it as a NOP
            if_id_instr <= bus.imem_instr_i;
            if_id_pc    <= pc;
            if_id_pc1   <= pc_plus1;
            if_id_valid <= 1'b1;
            if (fetch_count != 16'hFFFF)
               fetch_count <= fetch_count + 16'd1;
         end
      end
   end

   assign bus.imem_addr_o   = pc;
   assign bus.if_id_instr_o = if_id_instr;
   assign bus.if_id_pc_o    = if_id_pc;
   assign bus.if_id_pc1_o   = if_id_pc1;
   assign bus.if_id_valid_o = if_id_valid;
   assign bus.halted_o      = (state == ST_HALT);
   assign bus.fetch_count_o = fetch_count;

   logic unused_jump;
   assign unused_jump = is_jump;

endmodule
